counter_updown_3bit: RTL and testbench

COUNTER_UPDOWN_3BIT -- requirements
Module: counter_updown_3bit

---
 rtl/counter_updown_3bit_pkg.sv | 24 ++
 rtl/counter_updown_3bit_nsl.sv | 35 +++
 rtl/counter_updown_3bit.sv | 33 +++
 tb/tb_counter_updown_3bit.sv | 114 +++++++++++
 4 files changed

// File: rtl/counter_updown_3bit_pkg.sv
// Shared types and constants for the 3-bit up/down counter.
// Saturating mode is selected by COUNTER_UPDOWN_3BIT_SAT_EN.
package counter_updown_3bit_pkg;

   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4,
      S5 = 3'd5,
      S6 = 3'd6,
      S7 = 3'd7
   } state_e;

   localparam logic [STATE_W-1:0] STATE_MIN = 3'd0;
   localparam logic [STATE_W-1:0] STATE_MAX = 3'd7;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_updown_3bit_nsl.sv
// Next-state logic: modulo-8 step by default, clamped at the ends
// when COUNTER_UPDOWN_3BIT_SAT_EN is defined.
module counter_updown_3bit_nsl
   import counter_updown_3bit_pkg::*;
(
   input  state_e cur_i,
   input  logic   x_i,
   output state_e next_o
);

   logic [STATE_W-1:0] cur_raw;
   logic [STATE_W-1:0] nxt_raw;

   assign cur_raw = cur_i;

   always_comb begin
      nxt_raw = cur_raw;
      if (x_i == DIR_UP) begin
`ifdef COUNTER_UPDOWN_3BIT_SAT_EN
         nxt_raw = (cur_raw == STATE_MAX) ? STATE_MAX : cur_raw + 3'd1;
`else
         nxt_raw = cur_raw + 3'd1;
`endif
      end else begin
`ifdef COUNTER_UPDOWN_3BIT_SAT_EN
         nxt_raw = (cur_raw == STATE_MIN) ? STATE_MIN : cur_raw - 3'd1;
`else
         nxt_raw = cur_raw - 3'd1;
`endif
      end
   end

   assign next_o = state_e'(nxt_raw);

endmodule

// File: rtl/counter_updown_3bit.sv
// 3-bit up/down Moore counter; state is the register output.
// Optional saturation via COUNTER_UPDOWN_3BIT_SAT_EN (see next-state logic).
module counter_updown_3bit
   import counter_updown_3bit_pkg::*;
#(
   parameter logic [2:0] RESET_STATE = 3'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       x,
   output logic [2:0] state
);

   state_e state_q;
   state_e state_d;
   state_e nsl_next;

   counter_updown_3bit_nsl u_nsl (
      .cur_i  (state_q),
      .x_i    (x),
      .next_o (nsl_next)
   );

   // Reset wins over counting on the same edge.
   assign state_d = rst ? state_e'(RESET_STATE) : nsl_next;

   always_ff @(posedge clk) begin
      state_q <= state_d;
   end

   assign state = state_q;

endmodule

// File: tb/tb_counter_updown_3bit.sv
// Directed bench with a scoreboard queue for counter_updown_3bit.
// Expectations follow wrap or saturate mode from COUNTER_UPDOWN_3BIT_SAT_EN.
module tb_counter_updown_3bit;

   localparam logic [2:0] RST_VAL = 3'd0;

   logic       clk;
   logic       rst;
   logic       x;
   logic [2:0] state;

   logic [2:0] exp_state;
   logic [2:0] sb_q[$];
   int         checks;
   int         failures;

   counter_updown_3bit #(.RESET_STATE(RST_VAL)) dut (
      .clk   (clk),
      .rst   (rst),
      .x     (x),
      .state (state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [2:0] exp);
      checks++;
      assert (state === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, state, exp);
      end
   endtask

   function automatic logic [2:0] model(input logic r, input logic xv, input logic [2:0] cur);
      logic [2:0] n;
      if (r) n = RST_VAL;
`ifdef COUNTER_UPDOWN_3BIT_SAT_EN
      else if (xv) n = (cur == 3'd7) ? 3'd7 : 3'(cur + 3'd1);
      else         n = (cur == 3'd0) ? 3'd0 : 3'(cur - 3'd1);
`else
      else if (xv) n = 3'(cur + 3'd1);
      else         n = 3'(cur - 3'd1);
`endif
      return n;
   endfunction

   // Drive one edge's inputs, record the expectation, compare after the edge.
   task automatic step(input string tag, input logic r, input logic xv);
      rst = r;
      x   = xv;
      exp_state = model(r, xv, exp_state);
      sb_q.push_back(exp_state);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL %s observed=empty expected=entry", tag);
      end else begin
         check(tag, sb_q.pop_front());
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      exp_state = 3'd0;
      rst       = 1'b1;
      x         = 1'b1;

      step("reset_first", 1'b1, 1'b1);

      for (int i = 0; i < 9; i++) step("up_wrap", 1'b0, 1'b1);

      step("reset_a", 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step("down_wrap", 1'b0, 1'b0);

      step("reset_b", 1'b1, 1'b0);
      step("down_to7", 1'b0, 1'b0);
      step("reset_at_wrap", 1'b1, 1'b1);

      for (int i = 0; i < 8; i++) step("alternate", 1'b0, logic'((i / 2) % 2));

      step("reset_c", 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) step("up_to5", 1'b0, 1'b1);
      step("reset_mid", 1'b1, 1'b1);
      step("resume", 1'b0, 1'b1);

      // Inputs toggling between edges must not move state.
      x = ~x;
      #2;
      check("x_between_edges", exp_state);
      rst = 1'b1;
      #2;
      check("rst_between_edges", exp_state);
      step("rst_at_edge", 1'b1, x);

      for (int i = 0; i < 3; i++) step("down_from_min", 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step("up_to_max", 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
